// File: rtl/alu_pkg.sv
// alu_pkg: op codes, flag indices, FSM states and shift helpers for alu_shift_dr
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_CMP = 4'd5, OP_MOV = 4'd6,
                         OP_SLL = 4'd8, OP_SLR = 4'd9, OP_SRL = 4'd10, OP_SRA = 4'd11;
  localparam int FLG_S = 3, FLG_Z = 2, FLG_C = 1, FLG_V = 0;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic logic is_shift(logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction
  function automatic logic [3:0] mk_flags(logic [15:0] r, logic c, logic v);
    logic [3:0] f;
    f = '0;
    f[FLG_S] = r[15];
    f[FLG_Z] = r == 16'd0;
    f[FLG_C] = c;
    f[FLG_V] = v;
    return f;
  endfunction
  // One shift/rotate step: {bit shifted out, next work value}
  function automatic logic [16:0] shift_step(logic [3:0] op, logic [15:0] w);
    return op == OP_SLL ? {w[15], w[14:0], 1'b0} :
           op == OP_SLR ? {w[15], w[14:0], w[15]} :
           op == OP_SRL ? {w[0], 1'b0, w[15:1]} :
                          {w[0], w[15], w[15:1]};
  endfunction
endpackage

// File: rtl/alu16.sv
// alu16: combinational 16-bit add/sub/logic/move unit with carry and overflow
module alu16
  import alu_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  op,
  output logic [15:0] result,
  output logic        c,
  output logic        v
);
  logic sub, arith;
  logic [15:0] bx;
  logic [16:0] sum;
  always_comb begin
    sub = op == OP_SUB || op == OP_CMP;
    arith = sub || op == OP_ADD;
    bx = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {16'd0, sub};
    result = op == OP_AND ? a & b :
             op == OP_OR  ? a | b :
             op == OP_XOR ? a ^ b :
             op == OP_MOV ? b : sum[15:0];
    // subtract reports borrow, i.e. the inverted carry of a + ~b + 1
    c = arith & (sum[16] ^ sub);
    v = arith & (a[15] == bx[15]) & (sum[15] != a[15]);
  end
endmodule

// File: rtl/alu_shift_dr.sv
// alu_shift_dr: execute stage with one-cycle ALU ops and bit-serial shifts into DR/flags
module alu_shift_dr
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [3:0]  shamt,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic [15:0] dr_out,
  output logic [3:0]  flags_out,
  output logic        busy,
  output logic        done
);
  state_t state;
  logic [3:0] cnt, op_q;
  logic [15:0] work, res;
  logic c, v, sh_out;
  logic [15:0] sh_next;
  alu16 u_alu (.a(a_in), .b(b_in), .op(op), .result(res), .c(c), .v(v));
  assign {sh_out, sh_next} = shift_step(op_q, work);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op_q <= '0;
      work <= '0;
      dr_out <= '0;
      flags_out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && is_shift(op) && shamt != 4'd0) begin
          state <= SHIFT;
          busy <= 1'b1;
          work <= a_in;
          cnt <= shamt;
          op_q <= op;
        end else if (start) begin
          done <= 1'b1;
          if (is_shift(op)) begin
            dr_out <= a_in;
            flags_out <= mk_flags(a_in, 1'b0, 1'b0);
          end else if (op <= OP_MOV) begin
            if (op != OP_CMP) dr_out <= res;
            flags_out <= mk_flags(res, c, v);
          end
        end
      end else begin
        work <= sh_next;
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          dr_out <= sh_next;
          flags_out <= mk_flags(sh_next, sh_out, 1'b0);
        end
      end
    end
  end
endmodule

// File: doc/alu_shift_dr.md
# alu_shift_dr

Execute stage directly downstream of the Ra/Rb operand register pair. It takes the two 16-bit operands, performs the operation selected by the decoder, and writes the result into the DR (data result) register and the flag register {S,Z,C,V}. Arithmetic and logic ops complete in one cycle. Shifts and rotates run iteratively at one bit per cycle, and `busy`/`done` tell the controller when to advance the writeback phase.

## Interface
- No parameters; datapath fixed at 16 bits.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin operation; sampled only when busy=0.
- op  input  4  operation code, latched at the start edge.
- shamt  input  4  shift amount 0..15, latched at the start edge.
- a_in  input  16  operand A (Ra output).
- b_in  input  16  operand B (Rb output).
- dr_out  output  16  result register.
- flags_out  output  4  {S,Z,C,V}, registered.
- busy  output  1  high while an iterative shift is in progress.
- done  output  1  one-cycle pulse the cycle after dr_out/flags_out update.

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 CMP: SUB flags only, DR unchanged.
  - 6 MOV: DR=b.
  - 8 SLL, 9 SLR (rotate left), 10 SRL, 11 SRA. Shifts operate on A.
  - 7, 12–15 illegal: DR and flags unchanged, done still pulses.
- Flag rules:
  - S = result[15]; Z = (result==0).
  - ADD: C = carry out of bit 15; V = signed overflow.
  - SUB/CMP: result = a + ~b + 1; C = borrow, i.e. a<b unsigned; V = signed overflow.
  - Logic ops and MOV: C=0, V=0.
  - Shifts/rotates: C = last bit shifted or rotated out (0 when shamt=0); V=0.
- FSM states IDLE and SHIFT:
  - IDLE + start + non-shift op, or shift with shamt=0: write DR/flags at this edge, stay IDLE.
  - IDLE + start + shift with shamt≠0: load work register with a_in, cnt=shamt, go to SHIFT.
  - SHIFT: each edge shifts the work register one bit, captures the out-bit into C, and decrements cnt. On the edge where cnt==1: write DR and flags, return to IDLE.
- start while busy=1 is ignored; no queuing.
- Operands are latched at the start edge, so later changes to a_in/b_in have no effect.

## Timing
- Reset values: dr_out=0x0000, flags_out=4'b0000, busy=0, done=0, state=IDLE, cnt=0.
- One-cycle ops:
  - DR/flags visible the cycle after the start edge.
  - done=1 in that same cycle; busy stays 0.
- Shift with shamt=k (k≥1):
  - busy=1 from the cycle after the start edge through the k-th SHIFT edge.
  - DR/flags updated at the k-th edge after the start edge.
  - done=1 and busy=0 in the following cycle.
  - Total latency k cycles.
- A new start may be asserted in the same cycle done=1.
- Reset asserted mid-shift: immediate return to reset values. The partial result is discarded and no done is issued.
- Back-to-back one-cycle ops: one result per cycle; done stays high continuously.

## Structure
- Shared package `alu_pkg`:
  - op-code localparams (OP_ADD … OP_SRA).
  - flag bit indices (FLG_S=3, FLG_Z=2, FLG_C=1, FLG_V=0).
  - state encoding.
- Sub-module `alu16`: purely combinational. Inputs a, b, op; outputs result[15:0], c, v. Used for one-cycle ops.
- Top level holds the FSM, work register, counter, one-bit shift step logic, and the DR/flag registers.

## Test plan
- ADD a=0x7FFF, b=0x0001 → next cycle dr_out=0x8000, flags S=1 Z=0 C=0 V=1, done=1 for one cycle.
- SUB a=0x0003, b=0x0005 → dr_out=0xFFFE, S=1 Z=0 C=1 V=0. Then CMP a=b=0x1234 → Z=1, dr_out still 0xFFFE.
- SRA a=0x8001, shamt=3 → busy high 3 cycles, then dr_out=0xF000, C=0, done pulse. start asserted during busy with op=ADD is ignored.
- SLL a=0xC000, shamt=2 → dr_out=0x0000, Z=1, C=1. SLR a=0x8001, shamt=1 → dr_out=0x0003, C=1.
- Shift with shamt=0 and illegal op=7 → one-cycle completion. Shift gives dr_out=a and C=0; op 7 leaves DR/flags unchanged. done pulses in both cases.
- rst asserted on the 2nd cycle of an SRL with shamt=10 → outputs go to reset values immediately, no done. A following ADD 0x0001+0x0001 gives 0x0002.
